// File: rtl/mux_arb_nx1_pkg.sv
// Shared constants for the N:1 mux/arbiter: mode encodings and the beat counter width.
package mux_arb_nx1_pkg;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/mux_arb_nx1_rr_arb.sv
// N-way round-robin pick: first requesting channel found searching upward from ptr, modulo N.
module rr_arb_nx1 #(
  parameter int N  = 3,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any_req,
  output logic [SW-1:0] grant
);

  logic [SW:0] cand;

  assign any_req = |req;

  // Walk offsets from farthest to nearest so the channel closest to ptr wins last.
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (SW + 1)'(i);
      if (cand >= (SW + 1)'(N)) begin
        cand = cand - (SW + 1)'(N);
      end
      if (req[cand[SW-1:0]]) begin
        grant = cand[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 channel mux with static-select or round-robin arbitration feeding a single output register slot.
module mux_arb_nx1
  import mux_arb_nx1_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SW-1:0]         sel,
  input  logic [N*W-1:0]        in_data,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
  output logic [W-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SW-1:0]         out_chan,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  mode_e         cur_mode;
  logic          load_en;
  logic          rr_any;
  logic          grant_ok;
  logic          in_xfer;
  logic [SW-1:0] rr_grant;
  logic [SW-1:0] static_grant;
  logic [SW-1:0] grant;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic [W-1:0]  grant_data;

  assign cur_mode = mode_e'(mode);
  assign load_en  = !out_valid || out_ready;

  // Out-of-range select falls back to the last channel.
  assign static_grant = ({1'b0, sel} < (SW + 1)'(N)) ? sel : SW'(N - 1);

  rr_arb_nx1 #(
    .N  (N),
    .SW (SW)
  ) u_rr_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .any_req (rr_any),
    .grant   (rr_grant)
  );

  always_comb begin
    grant    = static_grant;
    grant_ok = 1'b1;
    if (cur_mode == MODE_RR) begin
      grant    = rr_grant;
      grant_ok = rr_any;
    end
  end

  always_comb begin
    in_ready = '0;
    if (!rst && load_en && grant_ok) begin
      in_ready = N'(1) << grant;
    end
  end

  assign in_xfer  = |(in_ready & in_valid);
  assign ptr_next = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  // A new beat overwrites the slot even when the old one leaves on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
      beat_cnt  <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
        beat_cnt  <= beat_cnt + BEAT_CNT_W'(1);
        if (cur_mode == MODE_RR) begin
          ptr <= ptr_next;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Scoreboard bench for mux_arb_nx1: a reference model predicts accepted beats, a monitor checks them as they leave.
module tb_mux_arb_nx1;
  import mux_arb_nx1_pkg::*;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] chan;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mode;
  logic [SW-1:0]         sel;
  logic [N*W-1:0]        in_data;
  logic [N-1:0]          in_valid;
  logic [N-1:0]          in_ready;
  logic [W-1:0]          out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SW-1:0]         out_chan;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  beat_t                 exp_q[$];
  bit                    m_out_valid = 1'b0;
  int                    m_ptr = 0;
  logic [BEAT_CNT_W-1:0] m_cnt = '0;

  always #5 clk = ~clk;

  mux_arb_nx1 #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .beat_cnt  (beat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: predict in_ready from the arbitration rules, compare state, then advance to the next edge.
  task automatic checkOutput();
    logic [N-1:0] exp_ready;
    int           g;
    bit           load_en;
    bit           xfer;
    exp_ready = '0;
    g         = -1;
    load_en   = !m_out_valid || out_ready;
    if (!rst) begin
      if (mode == MODE_STATIC) begin
        g = (int'(sel) < N) ? int'(sel) : N - 1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      if (g >= 0 && load_en) exp_ready[g] = 1'b1;
    end
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_out_valid));
    check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    xfer = |(exp_ready & in_valid);
    if (rst) begin
      m_out_valid = 1'b0;
      m_ptr       = 0;
      m_cnt       = '0;
      exp_q.delete();
    end else if (xfer) begin
      exp_q.push_back('{data: in_data[g*W +: W], chan: SW'(g)});
      m_out_valid = 1'b1;
      m_cnt       = m_cnt + 1'b1;
      if (mode == MODE_RR) m_ptr = (g + 1) % N;
    end else if (m_out_valid && out_ready) begin
      m_out_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic m, input logic [SW-1:0] s,
                               input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    mode      = m;
    sel       = s;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    checkOutput();
  endtask

  // Monitor: the held beat must match the oldest predicted beat; it retires when out_ready is high.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got data 0x%0h chan %0d, expected no beat at %0t",
                 out_data, out_chan, $time);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        check("out_chan", 32'(out_chan), 32'(exp_q[0].chan));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    mode      = MODE_STATIC;
    sel       = '0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    $display("[TB] reset with all channels offering");
    repeat (3) applyStimulus(1'b1, MODE_RR, 2'd0, 3'b111, 24'hAABBCC, 1'b1);

    $display("[TB] static select, out-of-range sel defaults to ch2");
    applyStimulus(1'b0, MODE_STATIC, 2'd3, 3'b100, {8'hC3, 8'h11, 8'h22}, 1'b1);
    applyStimulus(1'b0, MODE_STATIC, 2'd0, 3'b000, 24'h0, 1'b1);

    $display("[TB] round-robin, all channels valid");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, MODE_RR, 2'd0, 3'b111, {8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)}, 1'b1);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b000, 24'h0, 1'b1);
    check("beat_cnt_after_rr", 32'(beat_cnt), 32'd6);

    $display("[TB] backpressure with a held beat");
    applyStimulus(1'b0, MODE_STATIC, 2'd1, 3'b010, 24'h00A500, 1'b1);
    repeat (4) applyStimulus(1'b0, MODE_STATIC, 2'd1, 3'b111, 24'h5A5A5A, 1'b0);
    applyStimulus(1'b0, MODE_STATIC, 2'd1, 3'b010, 24'h007700, 1'b1);
    applyStimulus(1'b0, MODE_STATIC, 2'd1, 3'b000, 24'h0, 1'b1);

    $display("[TB] round-robin sparse request");
    applyStimulus(1'b1, MODE_RR, 2'd0, 3'b000, 24'h0, 1'b1);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b010, 24'h00E100, 1'b1);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b010, 24'h00E200, 1'b1);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b101, 24'hF300F4, 1'b1);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b000, 24'h0, 1'b1);

    $display("[TB] reset mid-stream drops the held beat");
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b100, 24'h990000, 1'b1);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b000, 24'h0, 1'b0);
    applyStimulus(1'b1, MODE_RR, 2'd0, 3'b111, 24'h123456, 1'b0);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b111, 24'hABCDEF, 1'b1);
    applyStimulus(1'b0, MODE_RR, 2'd0, 3'b000, 24'h0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom), 3'($urandom),
                    24'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("[TB] beat counter wrap");
    applyStimulus(1'b1, MODE_STATIC, 2'd0, 3'b000, 24'h0, 1'b1);
    for (int i = 0; i < 65536; i++) applyStimulus(1'b0, MODE_STATIC, 2'd0, 3'b001, 24'(i), 1'b1);
    applyStimulus(1'b0, MODE_STATIC, 2'd0, 3'b000, 24'h0, 1'b1);
    check("beat_cnt_wrap", 32'(beat_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_nx1.md
MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
REQ-001 Parameter N, default 3: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 1: data width per channel, legal range 1..64.
REQ-003 Parameter SW, default $clog2(N): width of the select and channel fields, derived and not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = static select, 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel select, used only when mode=0.
REQ-008 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready; at most one bit set per cycle.
REQ-011 out_data  output  W  registered data of the held beat.
REQ-012 out_valid  output  1  registered; high while a beat is held.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_chan  output  SW  registered index of the source channel of the held beat.
REQ-015 beat_cnt  output  16  count of accepted input beats, wraps from 0xFFFF to 0.

Function
REQ-016 Output stage SHALL be one register slot; the slot is free when out_valid=0 or out_ready=1 (load_en).
REQ-017 Handshake: an input beat transfers when in_valid[g] & in_ready[g]; an output beat transfers when out_valid & out_ready.
REQ-018 Latency: a beat accepted at edge k SHALL appear on out_data/out_valid after edge k; sustained throughput is one beat per cycle.
REQ-019 Mode 0: grant g = sel when sel < N; when sel >= N, g = N-1 (last channel is the default).
REQ-020 Mode 0: in_ready[g] = load_en and all other in_ready bits SHALL be 0; in_valid of the other channels is ignored.
REQ-021 Mode 1: g = first channel with in_valid set, searching from index ptr upward modulo N.
REQ-022 Mode 1: in_ready[g] = load_en when any in_valid is set; when no in_valid is set, in_ready = 0.
REQ-023 Round-robin pointer ptr (SW bits, reset 0) SHALL update to (g+1) mod N only on a mode-1 input transfer, wrapping N-1 -> 0.
REQ-024 ptr SHALL hold its value in mode 0 and on stall cycles.
REQ-025 On an input transfer: out_data <= in_data[g], out_chan <= g, out_valid <= 1, beat_cnt <= beat_cnt+1.
REQ-026 On an output transfer with no input transfer in the same cycle, out_valid <= 0 and out_data/out_chan SHALL hold.
REQ-027 Simultaneous output and input transfer SHALL replace the slot contents with no bubble.
REQ-028 While out_valid=1 and out_ready=0, out_data/out_chan SHALL be stable and in_ready SHALL be all 0.
REQ-029 mode or sel changes take effect in the same cycle for grant computation; a held beat is unaffected.
REQ-030 in_ready SHALL be combinational from mode, sel, in_valid, ptr, out_valid and out_ready; it SHALL NOT depend on in_data.

Reset
REQ-031 While rst=1 at a clock edge: out_valid=0, out_data=0, out_chan=0, ptr=0, beat_cnt=0.
REQ-032 While rst=1, in_ready SHALL be all 0; a beat offered during reset is not accepted.
REQ-033 Reset asserted mid-stream SHALL drop the held beat without an output transfer.
REQ-034 After reset, the first grant in mode 1 SHALL start the search at channel 0.

Structure
REQ-035 A shared package SHALL hold the mode encodings (MODE_STATIC=0, MODE_RR=1) and the beat_cnt width constant (16).
REQ-036 One sub-module, rr_arb_nx1 (N-way round-robin priority pick from ptr), is natural; the register slot and static-select logic stay in the top level.

Verification
REQ-037 Mode 0, N=3, W=8: sel=2'b11, ch2 valid with 0xC3, out_ready=1 -> in_ready=3'b100, next cycle out_data=0xC3, out_chan=2.
REQ-038 Mode 1: all three valid continuously, out_ready=1 -> out_chan sequence 0,1,2,0,1, one beat per cycle, beat_cnt=5.
REQ-039 Backpressure: out_ready=0 for 4 cycles with a beat held -> out_data stable, in_ready=0; out_ready=1 -> accepted beat is replaced the same cycle.
REQ-040 Mode 1 sparse: only ch1 valid after ptr=2 -> grant ch1, ptr becomes 2.
REQ-041 Wrap: force 65536 accepted beats -> beat_cnt returns to 0.
REQ-042 rst pulsed with out_valid=1, out_ready=0 -> next cycle out_valid=0, ptr=0, beat_cnt=0, no output transfer observed.
